// File: rtl/alu_flags_commit_if.sv
// Handshake bundle between the ALU result stage, the flags commit stage and register writeback.
// master = upstream/writeback side driving the stage, slave = alu_flags_commit itself.
interface alu_flags_commit_if #(
    parameter int DEST_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_size;
    logic [63:0]       in_result;
    logic              in_carry;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_result;
    logic [DEST_W-1:0] out_dest;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_size, in_result, in_carry, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_flags
    );

    modport slave (
        input  in_valid, in_size, in_result, in_carry, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_flags
    );
endinterface

// File: rtl/alu_flags_commit.sv
// Size-masks ALU results, derives {P,S,Z,C}, buffers them in a 2-entry skid buffer and commits flags on pop.
// Optional macro ALU_FLAGS_PARITY_EN builds the even-parity P flag; otherwise P is tied to 0.
module alu_flags_commit #(
    parameter int         DEST_W    = 5,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    alu_flags_commit_if.slave    bus,
    output logic [3:0]           flags_q
);

    typedef enum logic [1:0] {
        BITS_8  = 2'd0,
        BITS_16 = 2'd1,
        BITS_32 = 2'd2,
        BITS_64 = 2'd3
    } sizeFlags_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_t;

    typedef struct packed {
        logic [63:0]       result;
        logic [DEST_W-1:0] dest;
        logic [3:0]        flags;
    } entry_t;

    function automatic logic [63:0] maskResult(input sizeFlags_t sz, input logic [63:0] r);
        case (sz)
            BITS_8:  return {56'd0, r[7:0]};
            BITS_16: return {48'd0, r[15:0]};
            BITS_32: return {32'd0, r[31:0]};
            BITS_64: return r;
            default: return r;
        endcase
    endfunction

    function automatic logic signBit(input sizeFlags_t sz, input logic [63:0] r);
        case (sz)
            BITS_8:  return r[7];
            BITS_16: return r[15];
            BITS_32: return r[31];
            BITS_64: return r[63];
            default: return r[63];
        endcase
    endfunction

`ifdef ALU_FLAGS_PARITY_EN
    function automatic logic evenParity(input logic [63:0] r);
        return ~(^r);
    endfunction
`endif

    bufState_t  state_r, stateNext_s;
    entry_t     head_r, skid_r, inEntry_s;
    sizeFlags_t size_s;
    logic       outValid_r, inReady_r, accept_s, pop_s;
    logic       loadHeadIn_s, loadHeadSkid_s, loadSkid_s;
    logic [3:0] flags_r;
    logic [63:0] masked_s;
    logic       parity_s;

    // Build the buffer entry for the incoming result.
    always_comb begin
        size_s   = sizeFlags_t'(bus.in_size);
        masked_s = maskResult(size_s, bus.in_result);
`ifdef ALU_FLAGS_PARITY_EN
        parity_s = evenParity(masked_s);
`else
        parity_s = 1'b0;
`endif
        inEntry_s.result = masked_s;
        inEntry_s.dest   = bus.in_dest;
        inEntry_s.flags  = {parity_s, signBit(size_s, masked_s), (masked_s == 64'd0), bus.in_carry};
    end

    assign accept_s = bus.in_valid && inReady_r;
    assign pop_s    = outValid_r && bus.out_ready;

    // Next buffer state and which register slots load this cycle; flush discards any accepted input.
    always_comb begin
        stateNext_s    = state_r;
        loadHeadIn_s   = 1'b0;
        loadHeadSkid_s = 1'b0;
        loadSkid_s     = 1'b0;
        if (flush) begin
            stateNext_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        stateNext_s  = ONE;
                        loadHeadIn_s = 1'b1;
                    end else begin
                        stateNext_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && pop_s) begin
                        loadHeadIn_s = 1'b1;
                    end else if (accept_s) begin
                        stateNext_s = FULL;
                        loadSkid_s  = 1'b1;
                    end else if (pop_s) begin
                        stateNext_s = EMPTY;
                    end else begin
                        stateNext_s = ONE;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        stateNext_s    = ONE;
                        loadHeadSkid_s = 1'b1;
                    end else begin
                        stateNext_s = FULL;
                    end
                end
                default: stateNext_s = EMPTY;
            endcase
        end
    end

    // Buffer state, entry storage and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= EMPTY;
            head_r     <= '0;
            skid_r     <= '0;
            outValid_r <= 1'b0;
            inReady_r  <= 1'b1;
        end else begin
            state_r    <= stateNext_s;
            outValid_r <= (stateNext_s != EMPTY);
            inReady_r  <= (stateNext_s != FULL);
            if (loadHeadIn_s) begin
                head_r <= inEntry_s;
            end else if (loadHeadSkid_s) begin
                head_r <= skid_r;
            end else begin
                head_r <= head_r;
            end
            if (loadSkid_s) begin
                skid_r <= inEntry_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    // Architectural flags commit on every pop, including one that coincides with a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= FLAGS_RST;
        end else if (pop_s) begin
            flags_r <= head_r.flags;
        end else begin
            flags_r <= flags_r;
        end
    end

    assign bus.in_ready   = inReady_r;
    assign bus.out_valid  = outValid_r;
    assign bus.out_result = head_r.result;
    assign bus.out_dest   = head_r.dest;
    assign bus.out_flags  = head_r.flags;
    assign flags_q        = flags_r;

endmodule

// File: tb/tb_alu_flags_commit.sv
// Directed self-checking bench for alu_flags_commit; expected values are hand-computed constants.
module tb_alu_flags_commit;

`ifdef ALU_FLAGS_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic [3:0] RST_FLAGS = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [3:0] flagsQ;
    int nChecks = 0;
    int nFails = 0;

    alu_flags_commit_if #(.DEST_W(5)) bus ();

    alu_flags_commit #(.DEST_W(5), .FLAGS_RST(RST_FLAGS)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .flags_q(flagsQ)
    );

    always #5 clk = ~clk;

    // Streaming vectors: size, raw result, masked result, hand-derived P/S/Z (C = index LSB).
    logic [1:0]  sSz  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [63:0] sRes [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_8001, 64'hFFFF_FFFF_0000_0000,
                              64'h0000_0000_0000_0001, 64'h0000_0000_0000_0107, 64'h0000_0000_0001_7FFF,
                              64'h0000_0001_8000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] sExp [8] = '{64'h0000_0000_0000_00FF, 64'h0000_0000_0000_8001, 64'h0000_0000_0000_0000,
                              64'h0000_0000_0000_0001, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_7FFF,
                              64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000};
    logic sP [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic sS [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic sZ [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [3:0] fl(input logic p, input logic s, input logic z, input logic c);
        return {PAR_EN ? p : 1'b0, s, z, c};
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] expVal);
        nChecks++;
        if (act !== expVal) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, act, expVal);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sz, input logic [63:0] r, input logic c, input logic [4:0] d);
        bus.in_valid  = v;
        bus.in_size   = sz;
        bus.in_result = r;
        bus.in_carry  = c;
        bus.in_dest   = d;
    endtask

    logic [3:0] f1, f2, f3, fPrev, f22;

    initial begin
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        bus.out_ready = 1'b0;
        repeat (3) step();
        checkVal("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        checkVal("rst_out_result", bus.out_result, 64'd0);
        checkVal("rst_out_flags", {60'd0, bus.out_flags}, 64'd0);
        checkVal("rst_flags_q", {60'd0, flagsQ}, {60'd0, RST_FLAGS});
        rst = 1'b0;
        step();

        // Masking: 8-bit result 0x180 keeps 0x80, S=1, C=1, one set bit -> P=0.
        bus.out_ready = 1'b1;
        drive(1'b1, 2'd0, 64'h0000_0000_0000_0180, 1'b1, 5'd7);
        step();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        checkVal("mask_valid", {63'd0, bus.out_valid}, 64'd1);
        checkVal("mask_result", bus.out_result, 64'h80);
        checkVal("mask_dest", {59'd0, bus.out_dest}, 64'd7);
        checkVal("mask_flags", {60'd0, bus.out_flags}, {60'd0, fl(1'b0, 1'b1, 1'b0, 1'b1)});
        checkVal("mask_flagsq_hold", {60'd0, flagsQ}, {60'd0, RST_FLAGS});
        step();
        checkVal("mask_flagsq_commit", {60'd0, flagsQ}, {60'd0, fl(1'b0, 1'b1, 1'b0, 1'b1)});
        checkVal("mask_empty", {63'd0, bus.out_valid}, 64'd0);

        // Zero flag at 16 bits.
        drive(1'b1, 2'd1, 64'h0000_0000_FFFF_0000, 1'b0, 5'd3);
        step();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        checkVal("zero_result", bus.out_result, 64'd0);
        checkVal("zero_flags", {60'd0, bus.out_flags}, PAR_EN ? 64'hA : 64'h2);
        step();
        checkVal("zero_flagsq", {60'd0, flagsQ}, PAR_EN ? 64'hA : 64'h2);

        // Backpressure: three back-to-back entries with writeback stalled.
        f1 = fl(1'b1, 1'b1, 1'b0, 1'b0);
        f2 = fl(1'b1, 1'b0, 1'b1, 1'b1);
        f3 = fl(1'b1, 1'b1, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd3, 64'h8000_0000_0000_0001, 1'b0, 5'd1);
        step();
        checkVal("bp_ready_one", {63'd0, bus.in_ready}, 64'd1);
        drive(1'b1, 2'd2, 64'h0000_0001_0000_0000, 1'b1, 5'd2);
        step();
        checkVal("bp_ready_full", {63'd0, bus.in_ready}, 64'd0);
        drive(1'b1, 2'd0, 64'h0000_0000_0000_00FF, 1'b0, 5'd3);
        step();
        checkVal("bp_ready_held", {63'd0, bus.in_ready}, 64'd0);
        checkVal("bp_head_stable", {59'd0, bus.out_dest}, 64'd1);
        checkVal("bp_head_flags", {60'd0, bus.out_flags}, {60'd0, f1});
        bus.out_ready = 1'b1;
        step();
        checkVal("bp_pop1_dest", {59'd0, bus.out_dest}, 64'd2);
        checkVal("bp_pop1_flagsq", {60'd0, flagsQ}, {60'd0, f1});
        checkVal("bp_pop1_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        checkVal("bp_pop2_dest", {59'd0, bus.out_dest}, 64'd3);
        checkVal("bp_pop2_result", bus.out_result, 64'hFF);
        checkVal("bp_pop2_flagsq", {60'd0, flagsQ}, {60'd0, f2});
        step();
        checkVal("bp_drained", {63'd0, bus.out_valid}, 64'd0);
        checkVal("bp_pop3_flagsq", {60'd0, flagsQ}, {60'd0, f3});

        // Streaming: accept and pop every cycle across all sizes.
        fPrev = f3;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sSz[i], sRes[i], i[0], 5'(8 + i));
            step();
            checkVal($sformatf("st%0d_dest", i), {59'd0, bus.out_dest}, 64'(8 + i));
            checkVal($sformatf("st%0d_result", i), bus.out_result, sExp[i]);
            checkVal($sformatf("st%0d_flags", i), {60'd0, bus.out_flags}, {60'd0, fl(sP[i], sS[i], sZ[i], i[0])});
            checkVal($sformatf("st%0d_ready", i), {63'd0, bus.in_ready}, 64'd1);
            checkVal($sformatf("st%0d_flagsq", i), {60'd0, flagsQ}, {60'd0, fPrev});
            fPrev = fl(sP[i], sS[i], sZ[i], i[0]);
        end
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        step();
        checkVal("st_drain_flagsq", {60'd0, flagsQ}, {60'd0, fPrev});

        // Flush with FULL buffer and no pop: flags_q held.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd0, 64'h0000_0000_0000_0001, 1'b0, 5'd20);
        step();
        drive(1'b1, 2'd0, 64'h0000_0000_0000_0002, 1'b0, 5'd21);
        step();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkVal("fl_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("fl_ready", {63'd0, bus.in_ready}, 64'd1);
        checkVal("fl_flagsq_hold", {60'd0, flagsQ}, {60'd0, fPrev});

        // Flush coinciding with a pop commits; the input in that cycle is discarded.
        f22 = fl(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 2'd1, 64'h0000_0000_0001_0000, 1'b1, 5'd22);
        step();
        drive(1'b1, 2'd0, 64'h0000_0000_0000_0003, 1'b0, 5'd23);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        checkVal("flp_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("flp_flagsq", {60'd0, flagsQ}, {60'd0, f22});
        step();
        checkVal("flp_discard", {63'd0, bus.out_valid}, 64'd0);

        // Asynchronous reset between edges with the buffer FULL.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'd3, 64'h0000_0000_0000_0005, 1'b1, 5'd30);
        step();
        drive(1'b1, 2'd3, 64'h0000_0000_0000_0006, 1'b1, 5'd31);
        step();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        checkVal("ar_pre_full", {63'd0, bus.in_ready}, 64'd0);
        #2 rst = 1'b1;
        #1;
        checkVal("ar_valid", {63'd0, bus.out_valid}, 64'd0);
        checkVal("ar_ready", {63'd0, bus.in_ready}, 64'd1);
        checkVal("ar_result", bus.out_result, 64'd0);
        checkVal("ar_dest", {59'd0, bus.out_dest}, 64'd0);
        checkVal("ar_flagsq", {60'd0, flagsQ}, {60'd0, RST_FLAGS});
        #1 rst = 1'b0;
        step();
        drive(1'b1, 2'd0, 64'h0000_0000_0000_0100, 1'b0, 5'd9);
        step();
        drive(1'b0, 2'd0, 64'd0, 1'b0, 5'd0);
        checkVal("ar_first_valid", {63'd0, bus.out_valid}, 64'd1);
        checkVal("ar_first_dest", {59'd0, bus.out_dest}, 64'd9);
        checkVal("ar_first_flags", {60'd0, bus.out_flags}, {60'd0, fl(1'b1, 1'b0, 1'b1, 1'b0)});
        checkVal("ar_first_ready", {63'd0, bus.in_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
